slurm32_cpu_memory: RTL
=======================

SLURM32_CPU_MEMORY -- requirements
Module: slurm32_cpu_memory

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, default 255, bus cycles without progress before abort.
REQ-002 SHALL have port: CLK  input  1  clock, all state on rising edge.
REQ-003 SHALL have port: RSTb  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: load_memory  input  1  execute requests load this cycle.
REQ-005 SHALL have port: store_memory  input  1  execute requests store this cycle.
REQ-006 SHALL have port: load_store_address  input  30  word address.
REQ-007 SHALL have port: memory_out  input  32  store data, already lane-positioned.
REQ-008 SHALL have port: memory_mask  input  4  byte-lane enables, bit n = bits 8n+7:8n.
REQ-009 SHALL have port: load_signed  input  1  sign-extend byte/half loads.
REQ-010 SHALL have port: dest_reg  input  4  load destination register.
REQ-011 SHALL have ports: bus_valid out 1, bus_wr out 1, bus_addr out 30, bus_wdata out 32, bus_wmask out 4, bus_ready in 1 (request accepted), bus_rdata in 32, bus_rvalid in 1 (read data present).
REQ-012 SHALL have ports: stall out 1 (hold upstream), wb_valid out 1, wb_reg out 4, wb_data out 32, bus_error out 1 (one-cycle abort pulse).

Function
REQ-013 SHALL use states IDLE, REQ, WAIT_DATA.
REQ-014 Legal masks SHALL be 0001, 0010, 0100, 1000, 0011, 1100, 1111; any other mask is illegal.
REQ-015 In IDLE, load or store with legal mask SHALL latch address, data, mask, kind, load_signed, dest_reg and go to REQ next cycle.
REQ-016 Both load_memory and store_memory asserted SHALL be treated as a load; store is dropped.
REQ-017 Request with illegal mask SHALL pulse bus_error next cycle, issue no bus access, stay IDLE.
REQ-018 In REQ, bus_valid SHALL be 1 with latched fields stable; bus_wr = 1 for store.
REQ-019 REQ with bus_ready: store returns to IDLE; load goes to WAIT_DATA; bus_valid low next cycle.
REQ-020 In WAIT_DATA, bus_rvalid SHALL cause wb_valid = 1 for exactly the next cycle with wb_reg = latched dest_reg and aligned wb_data, then IDLE.
REQ-021 bus_rvalid in IDLE or REQ SHALL be ignored.
REQ-022 Load alignment: mask 1111 -> rdata; 0011/1100 -> half from lanes 1:0/3:2; single lane -> that byte; extended to 32 bits, sign if load_signed else zero.
REQ-023 stall SHALL be combinational: 1 in IDLE with any request (including illegal), 1 in REQ unless store with bus_ready, 1 in WAIT_DATA unless bus_rvalid, 1 on no other condition.
REQ-024 Timeout counter SHALL clear on entering REQ and on REQ->WAIT_DATA; increment each REQ/WAIT_DATA cycle without progress.
REQ-025 Counter reaching TIMEOUT_CYCLES SHALL pulse bus_error next cycle, return to IDLE, drop bus_valid, produce no wb_valid; stall low in the terminal cycle.
REQ-026 Memory request latency: bus_valid first high one cycle after acceptance; minimum load-to-wb_valid is 3 cycles (ready and rvalid each in first opportunity).
REQ-027 bus_wdata/bus_addr/bus_wmask SHALL hold their last latched values outside REQ.

Reset
REQ-028 RSTb low SHALL force IDLE, counter 0, bus_valid 0, bus_wr 0, bus_addr 0, bus_wdata 0, bus_wmask 0, wb_valid 0, wb_reg 0, wb_data 0, bus_error 0.
REQ-029 Reset during REQ or WAIT_DATA SHALL abandon the access with no wb_valid and no bus_error; late bus_rvalid after reset is ignored.

Structure
REQ-030 State encodings, legal-mask constants and default timeout SHALL live in shared package slurm32_cpu_mem_pkg.
REQ-031 Lane extraction/extension SHALL be combinational sub-module slurm32_cpu_load_align (inputs rdata, mask, signed; output 32-bit data).

Verification
REQ-032 Store addr 0x0000100, data 0x12345678, mask 1111, bus_ready on first REQ cycle -> one bus_valid cycle, bus_wr 1, stall high 1 cycle then low in REQ cycle, no wb_valid.
REQ-033 Load signed, mask 0100, rdata 0xAA80CCDD, dest 5 -> wb_valid one cycle, wb_reg 5, wb_data 0xFFFFFF80; unsigned -> 0x00000080.
REQ-034 Load mask 1100, rdata 0x8001_1234, unsigned, bus_ready delayed 3 cycles, rvalid delayed 2 -> wb_data 0x00008001, stall high throughout until rvalid cycle.
REQ-035 Load with mask 0101 -> bus_error pulse next cycle, bus_valid never asserted.
REQ-036 Load, bus_ready never asserted, TIMEOUT_CYCLES 255 -> bus_error pulse after 255 REQ cycles, state IDLE, no wb_valid; separately RSTb low mid-WAIT_DATA then rvalid -> no wb_valid.

Source files
------------

// File: rtl/slurm32_cpu_mem_pkg.sv
// Shared definitions for the slurm32 load/store unit: access FSM states,
// the set of legal byte-lane masks and the default bus timeout.
package slurm32_cpu_mem_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      REQ       = 2'd1,
      WAIT_DATA = 2'd2
   } mem_state_e;

   // Legal byte-lane masks: single bytes, aligned halves, full word
   localparam logic [3:0] MASK_B0 = 4'b0001;
   localparam logic [3:0] MASK_B1 = 4'b0010;
   localparam logic [3:0] MASK_B2 = 4'b0100;
   localparam logic [3:0] MASK_B3 = 4'b1000;
   localparam logic [3:0] MASK_H0 = 4'b0011;
   localparam logic [3:0] MASK_H1 = 4'b1100;
   localparam logic [3:0] MASK_W  = 4'b1111;

   localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

   function automatic logic mask_is_legal(input logic [3:0] mask);
      logic ok;
      case (mask)
         MASK_B0, MASK_B1, MASK_B2, MASK_B3,
         MASK_H0, MASK_H1, MASK_W: ok = 1'b1;
         default:                  ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/slurm32_cpu_load_align.sv
// Load data aligner: picks the byte/half/word selected by the lane mask
// out of the raw bus word and sign- or zero-extends it to 32 bits.
module slurm32_cpu_load_align
   import slurm32_cpu_mem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [3:0]  mask,
   input  logic        load_signed,
   output logic [31:0] data
);

   // Lane select and extension; illegal masks never reach here, return zero
   always_comb begin
      data = '0;
      case (mask)
         MASK_W:  data = rdata;
         MASK_H0: data = {{16{load_signed & rdata[15]}}, rdata[15:0]};
         MASK_H1: data = {{16{load_signed & rdata[31]}}, rdata[31:16]};
         MASK_B0: data = {{24{load_signed & rdata[7]}},  rdata[7:0]};
         MASK_B1: data = {{24{load_signed & rdata[15]}}, rdata[15:8]};
         MASK_B2: data = {{24{load_signed & rdata[23]}}, rdata[23:16]};
         MASK_B3: data = {{24{load_signed & rdata[31]}}, rdata[31:24]};
         default: data = '0;
      endcase
   end

endmodule

// File: rtl/slurm32_cpu_memory.sv
// slurm32 memory stage: accepts one load or store from execute, runs it
// over a simple valid/ready bus with separate read-data return, aligns
// load data for writeback and aborts stuck accesses after a timeout.
module slurm32_cpu_memory
   import slurm32_cpu_mem_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
)
(
   input  logic        CLK,
   input  logic        RSTb,
   input  logic        load_memory,
   input  logic        store_memory,
   input  logic [29:0] load_store_address,
   input  logic [31:0] memory_out,
   input  logic [3:0]  memory_mask,
   input  logic        load_signed,
   input  logic [3:0]  dest_reg,
   output logic        bus_valid,
   output logic        bus_wr,
   output logic [29:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_wmask,
   input  logic        bus_ready,
   input  logic [31:0] bus_rdata,
   input  logic        bus_rvalid,
   output logic        stall,
   output logic        wb_valid,
   output logic [3:0]  wb_reg,
   output logic [31:0] wb_data,
   output logic        bus_error
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   mem_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [29:0]       addr_q;
   logic [31:0]       wdata_q;
   logic [3:0]        mask_q;
   logic              is_load_q;
   logic              signed_q;
   logic [3:0]        dest_q;
   logic              wb_valid_q;
   logic [3:0]        wb_reg_q;
   logic [31:0]       wb_data_q;
   logic              bus_error_q;
   logic [31:0]       aligned;

   logic req_any, req_legal, accept, reject;
   logic req_done, data_done, progress, in_access, timeout_hit;

   always_comb begin
      req_any     = load_memory | store_memory;
      req_legal   = mask_is_legal(memory_mask);
      accept      = (state_q == IDLE) && req_any && req_legal;
      reject      = (state_q == IDLE) && req_any && !req_legal;
      req_done    = (state_q == REQ) && bus_ready;
      data_done   = (state_q == WAIT_DATA) && bus_rvalid;
      progress    = req_done | data_done;
      in_access   = (state_q == REQ) || (state_q == WAIT_DATA);
      timeout_hit = in_access && !progress && (cnt_q == CNT_LAST);
   end

   // State register
   always_ff @(posedge CLK) begin
      if (!RSTb) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (accept) state_d = REQ;
         REQ: begin
            if (bus_ready)        state_d = is_load_q ? WAIT_DATA : IDLE;
            else if (timeout_hit) state_d = IDLE;
         end
         WAIT_DATA: if (bus_rvalid || timeout_hit) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // Bus handshake and upstream stall outputs
   always_comb begin
      bus_valid = 1'b0;
      bus_wr    = 1'b0;
      stall     = 1'b0;
      case (state_q)
         IDLE:      stall = req_any;
         REQ: begin
            bus_valid = 1'b1;
            bus_wr    = !is_load_q;
            stall     = !(!is_load_q && bus_ready) && !timeout_hit;
         end
         WAIT_DATA: stall = !bus_rvalid && !timeout_hit;
         default:   stall = 1'b0;
      endcase
   end

   // Timeout counter next value: restarts per bus phase, counts idle cycles
   always_comb begin
      cnt_d = cnt_q;
      if (accept || req_done || timeout_hit) cnt_d = '0;
      else if (in_access && !progress)       cnt_d = cnt_q + 1'b1;
   end

   // Request capture and timeout counter
   always_ff @(posedge CLK) begin
      if (!RSTb) begin
         addr_q    <= '0;
         wdata_q   <= '0;
         mask_q    <= '0;
         is_load_q <= 1'b0;
         signed_q  <= 1'b0;
         dest_q    <= '0;
         cnt_q     <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (accept) begin
            addr_q    <= load_store_address;
            wdata_q   <= memory_out;
            mask_q    <= memory_mask;
            is_load_q <= load_memory;
            signed_q  <= load_signed;
            dest_q    <= dest_reg;
         end
      end
   end

   slurm32_cpu_load_align u_align (
      .rdata       (bus_rdata),
      .mask        (mask_q),
      .load_signed (signed_q),
      .data        (aligned)
   );

   // Writeback result and abort pulse registers
   always_ff @(posedge CLK) begin
      if (!RSTb) begin
         wb_valid_q  <= 1'b0;
         wb_reg_q    <= '0;
         wb_data_q   <= '0;
         bus_error_q <= 1'b0;
      end else begin
         wb_valid_q  <= data_done;
         bus_error_q <= reject | timeout_hit;
         if (data_done) begin
            wb_reg_q  <= dest_q;
            wb_data_q <= aligned;
         end
      end
   end

   assign bus_addr  = addr_q;
   assign bus_wdata = wdata_q;
   assign bus_wmask = mask_q;
   assign wb_valid  = wb_valid_q;
   assign wb_reg    = wb_reg_q;
   assign wb_data   = wb_data_q;
   assign bus_error = bus_error_q;

endmodule
